game_outcome: RTL and testbench

- Produces the `win`/`lose` inputs that the screen/level state FSM consumes, so it is the opposite side of that interface.
- Watches the FSM's 4-bit `current_state`. On entry to any level it loads that level's brick count and the initial lives.
- Counts brick-hit and ball-lost events from the ball/collision logic and raises `win` or `lose` until the FSM leaves the level.

---
 rtl/breakout_pkg.sv | 40 ++++
 rtl/level_params_rom.sv | 29 ++
 rtl/game_outcome.sv | 176 +++++++++++++++++
 tb/tb_game_outcome.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout screen/level logic.
//   - Screen/level state encodings driven by the level FSM (SM, LS, GO, L1..L8).
//   - Per-level brick counts BRICKS_L1..BRICKS_L8.
//   - is_level(): true for any level code (L1..L8, i.e. 3..10).
//   - outcome_state_e: internal state of the game_outcome tracker.
package breakout_pkg;

  localparam logic [3:0] SM = 4'b1111;
  localparam logic [3:0] LS = 4'b0001;
  localparam logic [3:0] GO = 4'b0010;
  localparam logic [3:0] L1 = 4'b0011;
  localparam logic [3:0] L2 = 4'b0100;
  localparam logic [3:0] L3 = 4'b0101;
  localparam logic [3:0] L4 = 4'b0110;
  localparam logic [3:0] L5 = 4'b0111;
  localparam logic [3:0] L6 = 4'b1000;
  localparam logic [3:0] L7 = 4'b1001;
  localparam logic [3:0] L8 = 4'b1010;

  localparam int unsigned BRICKS_L1 = 8;
  localparam int unsigned BRICKS_L2 = 12;
  localparam int unsigned BRICKS_L3 = 16;
  localparam int unsigned BRICKS_L4 = 20;
  localparam int unsigned BRICKS_L5 = 24;
  localparam int unsigned BRICKS_L6 = 28;
  localparam int unsigned BRICKS_L7 = 32;
  localparam int unsigned BRICKS_L8 = 40;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StDoneWin,
    StDoneLose
  } outcome_state_e;

  function automatic logic is_level(input logic [3:0] code);
    return (code >= L1) && (code <= L8);
  endfunction

endpackage

// File: rtl/level_params_rom.sv
// Combinational brick-count lookup for the current screen/level code.
// Ports:
//   current_state  in   4        screen/level code from the level FSM
//   brick_count    out  BRICK_W  bricks for that level; 0 for non-level codes
module level_params_rom
  import breakout_pkg::*;
#(
  parameter int unsigned BRICK_W = 6
) (
  input  logic [3:0]         current_state,
  output logic [BRICK_W-1:0] brick_count
);

  always_comb begin
    brick_count = '0;
    case (current_state)
      L1:      brick_count = BRICK_W'(BRICKS_L1);
      L2:      brick_count = BRICK_W'(BRICKS_L2);
      L3:      brick_count = BRICK_W'(BRICKS_L3);
      L4:      brick_count = BRICK_W'(BRICKS_L4);
      L5:      brick_count = BRICK_W'(BRICKS_L5);
      L6:      brick_count = BRICK_W'(BRICKS_L6);
      L7:      brick_count = BRICK_W'(BRICKS_L7);
      L8:      brick_count = BRICK_W'(BRICKS_L8);
      default: brick_count = '0;
    endcase
  end

endmodule

// File: rtl/game_outcome.sv
// Level outcome tracker: produces win/lose for the screen/level FSM.
// On entry to a level it loads that level's brick count and LIVES_INIT lives,
// then counts brick_hit / ball_lost pulses and raises win or lose until the
// FSM leaves the level.
// Ports:
//   clk            in   1        system clock, posedge
//   reset          in   1        synchronous active-high reset
//   current_state  in   4        screen/level code from the level FSM
//   brick_hit      in   1        one-cycle pulse, one brick destroyed
//   ball_lost      in   1        one-cycle pulse, ball fell below paddle
//   win            out  1        level cleared, held until level exit
//   lose           out  1        lives exhausted, held until level exit
//   bricks_left    out  BRICK_W  remaining bricks
//   lives          out  LIFE_W   remaining lives
// Build option: define EXTRA_LIFE_EN to award one life every EXTRA_LIFE_EVERY
// bricks cleared (saturating at 2^LIFE_W-1).
module game_outcome
  import breakout_pkg::*;
#(
  parameter int unsigned LIVES_INIT       = 3,
  parameter int unsigned BRICK_W          = 6,
  parameter int unsigned LIFE_W           = 2,
  parameter int unsigned EXTRA_LIFE_EVERY = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         current_state,
  input  logic               brick_hit,
  input  logic               ball_lost,
  output logic               win,
  output logic               lose,
  output logic [BRICK_W-1:0] bricks_left,
  output logic [LIFE_W-1:0]  lives
);

  outcome_state_e     state_q, state_d;
  logic [3:0]         prev_state_q;
  logic [BRICK_W-1:0] bricks_q, bricks_d;
  logic [LIFE_W-1:0]  lives_q, lives_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic [BRICK_W-1:0] level_bricks;

  logic in_level;
  logic level_entry;
  logic hit_acc;
  logic final_hit;
  logic lost_acc;
  logic bonus;

  level_params_rom #(
    .BRICK_W (BRICK_W)
  ) u_rom (
    .current_state (current_state),
    .brick_count   (level_bricks)
  );

  assign in_level = is_level(current_state);
  // A direct switch between two level codes is also an entry.
  assign level_entry = in_level && (current_state != prev_state_q);

  assign hit_acc   = brick_hit && (bricks_q != '0);
  assign final_hit = hit_acc && (bricks_q == BRICK_W'(1));
  assign lost_acc  = ball_lost && (lives_q != '0);

`ifdef EXTRA_LIFE_EN
  logic [BRICK_W-1:0] cleared_q, cleared_d;
  logic [BRICK_W-1:0] cleared_inc;

  assign cleared_inc = cleared_q + BRICK_W'(1);
  // The final hit ends the level, so it never earns a bonus.
  assign bonus = hit_acc && !final_hit && (EXTRA_LIFE_EVERY != 0) &&
                 ((32'(cleared_inc) % EXTRA_LIFE_EVERY) == 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cleared_q <= '0;
    end else begin
      cleared_q <= cleared_d;
    end
  end

  always_comb begin
    cleared_d = cleared_q;
    if (level_entry) begin
      cleared_d = '0;
    end else if ((state_q == StPlay) && in_level && hit_acc) begin
      cleared_d = cleared_inc;
    end
  end
`else
  assign bonus = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      prev_state_q <= 4'b0000;
      bricks_q     <= '0;
      lives_q      <= '0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_state_q <= current_state;
      bricks_q     <= bricks_d;
      lives_q      <= lives_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bricks_d = bricks_q;
    lives_d  = lives_q;
    win_d    = win_q;
    lose_d   = lose_q;

    if (level_entry) begin
      state_d  = StPlay;
      bricks_d = level_bricks;
      lives_d  = LIFE_W'(LIVES_INIT);
      win_d    = 1'b0;
      lose_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Events ignored; counters hold for display.
        end
        StPlay: begin
          if (!in_level) begin
            state_d = StIdle;
          end else if ((bricks_q == '0) || final_hit) begin
            // Win beats a simultaneous final ball loss: lives untouched.
            state_d  = StDoneWin;
            bricks_d = '0;
            win_d    = 1'b1;
          end else begin
            if (hit_acc) begin
              bricks_d = bricks_q - BRICK_W'(1);
            end
            // A bonus life and a lost ball in the same cycle cancel out.
            if (lost_acc && !bonus) begin
              lives_d = lives_q - LIFE_W'(1);
              if (lives_q == LIFE_W'(1)) begin
                state_d = StDoneLose;
                lose_d  = 1'b1;
              end
            end else if (bonus && !lost_acc) begin
              if (lives_q != '1) begin
                lives_d = lives_q + LIFE_W'(1);
              end
            end
          end
        end
        StDoneWin, StDoneLose: begin
          if (!in_level) begin
            state_d = StIdle;
            win_d   = 1'b0;
            lose_d  = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign win         = win_q;
  assign lose        = lose_q;
  assign bricks_left = bricks_q;
  assign lives       = lives_q;

endmodule

// File: tb/tb_game_outcome.sv
module tb_game_outcome;
  import breakout_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] current_state;
  logic       brick_hit;
  logic       ball_lost;
  logic       win;
  logic       lose;
  logic [5:0] bricks_left;
  logic [1:0] lives;

  int n_checks;
  int n_fail;

  game_outcome dut (
    .clk           (clk),
    .reset         (reset),
    .current_state (current_state),
    .brick_hit     (brick_hit),
    .ball_lost     (ball_lost),
    .win           (win),
    .lose          (lose),
    .bricks_left   (bricks_left),
    .lives         (lives)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs driven here are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    current_state = SM;
    step();
    step();
    reset = 1'b0;
    step();
    n_checks++; if (win !== 1'b0) begin n_fail++; $display("FAIL rst_win got=%b exp=0", win); end
    n_checks++; if (lose !== 1'b0) begin n_fail++; $display("FAIL rst_lose got=%b exp=0", lose); end
    n_checks++; if (bricks_left !== 6'd0) begin n_fail++; $display("FAIL rst_bricks got=%0d exp=0", bricks_left); end
    n_checks++; if (lives !== 2'd0) begin n_fail++; $display("FAIL rst_lives got=%0d exp=0", lives); end
    brick_hit = 1'b1;
    step();
    step();
    brick_hit = 1'b0;
    step();
    n_checks++; if (bricks_left !== 6'd0 || win !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignore bricks=%0d win=%b exp 0/0", bricks_left, win);
    end
  endtask

  task automatic test_win();
    current_state = L1;
    step();
    n_checks++; if (bricks_left !== 6'd8) begin n_fail++; $display("FAIL l1_load got=%0d exp=8", bricks_left); end
    n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL l1_lives got=%0d exp=3", lives); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (win !== 1'b0) begin n_fail++; $display("FAIL win_early hit=%0d got=%b exp=0", i, win); end
      brick_hit = 1'b1;
      step();
      brick_hit = 1'b0;
      n_checks++; if (bricks_left !== 6'(7 - i)) begin
        n_fail++; $display("FAIL l1_count hit=%0d got=%0d exp=%0d", i, bricks_left, 7 - i);
      end
      step();
      step();
    end
    n_checks++; if (win !== 1'b1 || lose !== 1'b0) begin
      n_fail++; $display("FAIL win_held win=%b lose=%b exp 1/0", win, lose);
    end
    current_state = LS;
    step();
    n_checks++; if (win !== 1'b0) begin n_fail++; $display("FAIL win_clear got=%b exp=0", win); end
    n_checks++; if (bricks_left !== 6'd0) begin n_fail++; $display("FAIL win_disp got=%0d exp=0", bricks_left); end
  endtask

  task automatic test_lose();
    current_state = L3;
    step();
    n_checks++; if (bricks_left !== 6'd16) begin n_fail++; $display("FAIL l3_load got=%0d exp=16", bricks_left); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (lose !== 1'b0) begin n_fail++; $display("FAIL lose_early lost=%0d got=%b exp=0", i, lose); end
      ball_lost = 1'b1;
      step();
      ball_lost = 1'b0;
      n_checks++; if (lives !== 2'(2 - i)) begin
        n_fail++; $display("FAIL lives_count lost=%0d got=%0d exp=%0d", i, lives, 2 - i);
      end
      step();
    end
    n_checks++; if (lose !== 1'b1 || win !== 1'b0) begin
      n_fail++; $display("FAIL lose_held lose=%b win=%b exp 1/0", lose, win);
    end
    brick_hit = 1'b1;
    step();
    step();
    brick_hit = 1'b0;
    step();
    n_checks++; if (bricks_left !== 6'd16) begin n_fail++; $display("FAIL done_ignore got=%0d exp=16", bricks_left); end
    current_state = GO;
    step();
    n_checks++; if (lose !== 1'b0) begin n_fail++; $display("FAIL lose_clear got=%b exp=0", lose); end
    n_checks++; if (lives !== 2'd0) begin n_fail++; $display("FAIL lose_disp got=%0d exp=0", lives); end
  endtask

  task automatic test_simultaneous();
    current_state = L1;
    step();
    brick_hit = 1'b1;
    repeat (7) step();
    brick_hit = 1'b0;
    ball_lost = 1'b1;
    repeat (2) step();
    ball_lost = 1'b0;
    n_checks++; if (bricks_left !== 6'd1 || lives !== 2'd1) begin
      n_fail++; $display("FAIL sim_setup bricks=%0d lives=%0d exp 1/1", bricks_left, lives);
    end
    brick_hit = 1'b1;
    ball_lost = 1'b1;
    step();
    brick_hit = 1'b0;
    ball_lost = 1'b0;
    n_checks++; if (win !== 1'b1 || lose !== 1'b0) begin
      n_fail++; $display("FAIL sim_prio win=%b lose=%b exp 1/0", win, lose);
    end
    n_checks++; if (lives !== 2'd1 || bricks_left !== 6'd0) begin
      n_fail++; $display("FAIL sim_counts lives=%0d bricks=%0d exp 1/0", lives, bricks_left);
    end
    current_state = LS;
    step();
  endtask

  task automatic test_level_switch();
    current_state = L2;
    step();
    brick_hit = 1'b1;
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
    n_checks++; if (bricks_left !== 6'd11 || lives !== 2'd2) begin
      n_fail++; $display("FAIL both_dec bricks=%0d lives=%0d exp 11/2", bricks_left, lives);
    end
    repeat (4) step();
    brick_hit = 1'b0;
    n_checks++; if (bricks_left !== 6'd7) begin n_fail++; $display("FAIL l2_hits got=%0d exp=7", bricks_left); end
    current_state = L4;
    step();
    n_checks++; if (bricks_left !== 6'd20 || lives !== 2'd3) begin
      n_fail++; $display("FAIL l4_reload bricks=%0d lives=%0d exp 20/3", bricks_left, lives);
    end
    brick_hit = 1'b1;
    step();
    brick_hit = 1'b0;
    n_checks++; if (bricks_left !== 6'd19) begin n_fail++; $display("FAIL l4_hit got=%0d exp=19", bricks_left); end
    reset = 1'b1;
    step();
    n_checks++; if (bricks_left !== 6'd0 || lives !== 2'd0 || win !== 1'b0 || lose !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset bricks=%0d lives=%0d win=%b lose=%b exp all 0",
                         bricks_left, lives, win, lose);
    end
    current_state = SM;
    reset = 1'b0;
    brick_hit = 1'b1;
    step();
    brick_hit = 1'b0;
    n_checks++; if (bricks_left !== 6'd0 || lives !== 2'd0) begin
      n_fail++; $display("FAIL post_reset bricks=%0d lives=%0d exp 0/0", bricks_left, lives);
    end
  endtask

  task automatic test_extra_life();
    logic [1:0] exp_l5;
    logic [1:0] exp_cancel;
`ifdef EXTRA_LIFE_EN
    exp_l5     = 2'd3;
    exp_cancel = 2'd3;
`else
    exp_l5     = 2'd2;
    exp_cancel = 2'd2;
`endif
    current_state = L5;
    step();
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
    n_checks++; if (lives !== 2'd2) begin n_fail++; $display("FAIL l5_lost got=%0d exp=2", lives); end
    brick_hit = 1'b1;
    repeat (16) step();
    brick_hit = 1'b0;
    n_checks++; if (lives !== exp_l5) begin n_fail++; $display("FAIL bonus got=%0d exp=%0d", lives, exp_l5); end
    n_checks++; if (bricks_left !== 6'd8 || win !== 1'b0) begin
      n_fail++; $display("FAIL l5_bricks bricks=%0d win=%b exp 8/0", bricks_left, win);
    end
    current_state = L8;
    step();
    brick_hit = 1'b1;
    repeat (16) step();
    brick_hit = 1'b0;
    n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL bonus_sat got=%0d exp=3", lives); end
    brick_hit = 1'b1;
    repeat (15) step();
    ball_lost = 1'b1;
    step();
    brick_hit = 1'b0;
    ball_lost = 1'b0;
    n_checks++; if (lives !== exp_cancel || lose !== 1'b0) begin
      n_fail++; $display("FAIL bonus_cancel lives=%0d lose=%b exp %0d/0", lives, lose, exp_cancel);
    end
    n_checks++; if (bricks_left !== 6'd8) begin n_fail++; $display("FAIL l8_bricks got=%0d exp=8", bricks_left); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    current_state = SM;
    brick_hit = 1'b0;
    ball_lost = 1'b0;
    test_reset();
    test_win();
    test_lose();
    test_simultaneous();
    test_level_switch();
    test_extra_life();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
